// File: rtl/jt900h_memctl.sv
`default_nettype none
// jt900h_memctl: bridges the core's zero-wait bus to a req/ack memory port, with a
// one-word read buffer, core stalling through cpu_cen and a watchdog on memory requests.
module jt900h_memctl #(
    parameter int AW      = 24,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_in,
    output logic          cpu_cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    cpu_we,
    output logic [15:0]   cpu_din,
    input  logic          inval,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-2:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_we,
    input  logic          mem_ack,
    input  logic [15:0]   mem_dout,
    output logic          bus_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t        state;
    logic          valid;
    logic          done;
    logic [AW-2:0] tag;
    logic [7:0]    timer;

    logic [AW-2:0] word;
    logic          hit;
    logic          wr_hit;
    logic          expired;
    logic          unused_lsb;

    // Byte lane selection is left to the core, so the address LSB is not needed here.
    assign unused_lsb = cpu_addr[0];
    assign word       = cpu_addr[AW-1:1];
    assign hit        = valid && (tag == word);
    assign wr_hit     = valid && (tag == mem_addr);
    assign expired    = (timer == TLAST);
    assign cpu_cen    = cen_in && (state == IDLE) && (done || ((cpu_we == 2'b00) && hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= 1'b0;
            done     <= 1'b0;
            tag      <= '0;
            timer    <= 8'd0;
            cpu_din  <= 16'h0000;
            mem_req  <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 16'h0000;
            mem_we   <= 2'b00;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cen_in) begin
                        if (done) begin
                            done <= 1'b0;
                        end else if (cpu_we != 2'b00) begin
                            state    <= WRITE;
                            mem_req  <= 1'b1;
                            mem_wr   <= 1'b1;
                            mem_addr <= word;
                            mem_din  <= cpu_dout;
                            mem_we   <= cpu_we;
                            timer    <= 8'd0;
                        end else if (!hit) begin
                            state    <= READ;
                            mem_req  <= 1'b1;
                            mem_wr   <= 1'b0;
                            mem_addr <= word;
                            mem_we   <= 2'b00;
                            timer    <= 8'd0;
                        end
                    end
                end
                READ: begin
                    timer <= timer + 8'd1;
                    if (mem_ack) begin
                        cpu_din <= mem_dout;
                        tag     <= mem_addr;
                        valid   <= 1'b1;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else if (expired) begin
                        cpu_din <= 16'hFFFF;
                        valid   <= 1'b0;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WRITE: begin
                    timer <= timer + 8'd1;
                    if (mem_ack) begin
                        // Write-through: keep the buffered copy coherent, never allocate.
                        if (wr_hit && mem_we[1]) cpu_din[15:8] <= mem_din[15:8];
                        if (wr_hit && mem_we[0]) cpu_din[7:0]  <= mem_din[7:0];
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidation overrides a read fill landing in the same cycle.
            if (inval) valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jt900h_memctl.sv
`default_nettype none
// Bench for jt900h_memctl: vector table, corner sequences (timeout, inval on ack, reset
// mid-request) and random traffic against a word-level memory/buffer model.
module tb_jt900h_memctl;
    localparam int AW  = 24;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen_in;
    logic        cpu_cen;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_din;
    logic        inval, inval_drv, inval_rsp;
    logic        mem_req, mem_wr;
    logic [22:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_ack, ack_rsp, ack_force;
    logic [15:0] mem_dout;
    logic        bus_err;

    assign inval   = inval_drv | inval_rsp;
    assign mem_ack = ack_rsp | ack_force;

    always #5 clk = ~clk;

    jt900h_memctl #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .cpu_cen(cpu_cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .inval(inval), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_we(mem_we), .mem_ack(mem_ack), .mem_dout(mem_dout),
        .bus_err(bus_err)
    );

    // Memory device: acks ack_dly cycles after a request, records request fields.
    logic [15:0] dev_mem [0:4095];
    int          ack_dly = 1;
    bit          ack_en = 1'b1;
    bit          inval_on_ack = 1'b0;
    int          age, req_rises, err_pulses, stab_err;
    logic [22:0] r_addr;
    logic        r_wr;
    logic [1:0]  r_we;
    logic [15:0] r_din;
    bit          prev_req;

    initial begin
        for (int i = 0; i < 4096; i++) dev_mem[i] = {i[7:0], ~i[7:0]};
        ack_rsp = 1'b0; inval_rsp = 1'b0; mem_dout = 16'h0;
        age = 0; req_rises = 0; err_pulses = 0; stab_err = 0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            ack_rsp   = 1'b0;
            inval_rsp = 1'b0;
            if (bus_err) err_pulses++;
            if (mem_req) begin
                if (!prev_req) begin
                    req_rises++;
                    r_addr = mem_addr; r_wr = mem_wr; r_we = mem_we; r_din = mem_din;
                    age = 0;
                end else if (mem_addr !== r_addr || mem_wr !== r_wr || mem_we !== r_we ||
                             (r_wr && mem_din !== r_din)) begin
                    stab_err++;
                end
                age++;
                if (ack_en && age == ack_dly) begin
                    ack_rsp   = 1'b1;
                    inval_rsp = inval_on_ack;
                    if (mem_wr) begin
                        if (mem_we[1]) dev_mem[mem_addr[11:0]][15:8] = mem_din[15:8];
                        if (mem_we[0]) dev_mem[mem_addr[11:0]][7:0]  = mem_din[7:0];
                    end else begin
                        mem_dout = dev_mem[mem_addr[11:0]];
                    end
                end
            end else begin
                age = 0;
            end
            prev_req = mem_req;
        end
    end

    // Reference model: what the core should observe, in terms of words and one cached word.
    logic [15:0] ref_mem [0:4095];
    bit          ref_valid;
    logic [22:0] ref_tag;

    function automatic bit model_hit(input logic [23:0] a);
        return ref_valid && (ref_tag == a[23:1]);
    endfunction

    function automatic void model_commit(input logic [23:0] a, input logic [1:0] w,
                                         input logic [15:0] d, input bit aborted);
        logic [11:0] ix;
        ix = a[12:1];
        if (w != 2'b00) begin
            if (!aborted) begin
                if (w[1]) ref_mem[ix][15:8] = d[15:8];
                if (w[0]) ref_mem[ix][7:0]  = d[7:0];
            end
        end else if (!model_hit(a)) begin
            ref_valid = !aborted;
            ref_tag   = a[23:1];
        end
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input logic [23:0] a, input logic [1:0] w, input logic [15:0] d,
                          input int dly, input int dead,
                          output logic [15:0] rd, output int stall, output int reqs, output int errs);
        int r0, e0;
        r0 = req_rises; e0 = err_pulses; ack_dly = dly;
        cpu_addr = a; cpu_we = w; cpu_dout = d; cen_in = 1'b0;
        for (int i = 0; i < dead; i++) begin
            #1 check("dead_cycle_cen", 32'(cpu_cen), 32'd0);
            @(negedge clk);
        end
        cen_in = 1'b1;
        stall = 0;
        for (int guard = 0; guard < 400; guard++) begin
            #1;
            if (cpu_cen) break;
            @(negedge clk);
            stall++;
        end
        if (!cpu_cen) check("cen_wait_bound", 32'(cpu_cen), 32'd1);
        rd = cpu_din;
        @(negedge clk);
        reqs = req_rises - r0;
        errs = err_pulses - e0;
    endtask

    task automatic apply(input string nm, input logic [23:0] a, input logic [1:0] w,
                         input logic [15:0] d, input int dly, input int dead,
                         input bit chk_din, input logic [15:0] exp_din,
                         input int exp_reqs, input int exp_stall, input int exp_errs);
        logic [15:0] rd;
        int st, rq, er;
        access(a, w, d, dly, dead, rd, st, rq, er);
        if (chk_din) check({nm, "_din"}, 32'(rd), 32'(exp_din));
        check({nm, "_reqs"}, 32'(rq), 32'(exp_reqs));
        check({nm, "_stall"}, 32'(st), 32'(exp_stall));
        check({nm, "_buserr"}, 32'(er), 32'(exp_errs));
        if (rq == 1) begin
            check({nm, "_mem_addr"}, 32'(r_addr), 32'(a[23:1]));
            check({nm, "_mem_wr"}, 32'(r_wr), 32'(w != 2'b00));
            check({nm, "_mem_we"}, 32'(r_we), 32'(w));
            if (w != 2'b00) check({nm, "_mem_din"}, 32'(r_din), 32'(d));
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [1:0]  we;
        logic [15:0] data;
        int          dly;
        bit          chk_din;
        logic [15:0] din;
        int          reqs;
        int          stall;
    } vec_t;

    vec_t vt [9];

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [23:0] a;
        logic [1:0]  w;
        logic [15:0] d;
        int          dly, dead;
        bit          h;

        vt[0] = '{24'h000400, 2'b00, 16'h0000, 3, 1'b1, 16'h00FF, 1, 4};
        vt[1] = '{24'h000400, 2'b00, 16'h0000, 1, 1'b1, 16'h00FF, 0, 0};
        vt[2] = '{24'h000401, 2'b00, 16'h0000, 1, 1'b1, 16'h00FF, 0, 0};
        vt[3] = '{24'h000400, 2'b10, 16'hAB12, 2, 1'b0, 16'h0000, 1, 3};
        vt[4] = '{24'h000400, 2'b00, 16'h0000, 1, 1'b1, 16'hABFF, 0, 0};
        vt[5] = '{24'h000402, 2'b00, 16'h0000, 1, 1'b1, 16'h01FE, 1, 2};
        vt[6] = '{24'h000600, 2'b11, 16'h1234, 1, 1'b0, 16'h0000, 1, 2};
        vt[7] = '{24'h000402, 2'b00, 16'h0000, 1, 1'b1, 16'h01FE, 0, 0};
        vt[8] = '{24'h000600, 2'b00, 16'h0000, 2, 1'b1, 16'h1234, 1, 3};

        for (int i = 0; i < 4096; i++) ref_mem[i] = {i[7:0], ~i[7:0]};
        ref_valid = 1'b0; ref_tag = '0;
        inval_drv = 1'b0; ack_force = 1'b0;
        cpu_addr = 24'h0; cpu_dout = 16'h0; cpu_we = 2'b00;

        // Reset values, with cen_in high so cpu_cen is not trivially gated off.
        rst_n = 1'b0; cen_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cpu_cen", 32'(cpu_cen), 32'd0);
        check("rst_cpu_din", 32'(cpu_din), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        cen_in = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            apply($sformatf("vec%0d", i), vt[i].addr, vt[i].we, vt[i].data, vt[i].dly, 0,
                  vt[i].chk_din, vt[i].din, vt[i].reqs, vt[i].stall, 0);
            model_commit(vt[i].addr, vt[i].we, vt[i].data, 1'b0);
        end

        // Read that is never acked: watchdog abort.
        ack_en = 1'b0;
        apply("rd_timeout", 24'h000800, 2'b00, 16'h0, 1, 0, 1'b1, 16'hFFFF, 1, TMO + 1, 1);
        check("bus_err_one_cycle", 32'(bus_err), 32'd0);
        model_commit(24'h000800, 2'b00, 16'h0, 1'b1);
        ack_en = 1'b1;
        apply("rd_after_timeout", 24'h000800, 2'b00, 16'h0, 2, 0, 1'b1, ref_mem[12'h400], 1, 3, 0);
        model_commit(24'h000800, 2'b00, 16'h0, 1'b0);

        // Write that is never acked is dropped, buffered word untouched.
        ack_en = 1'b0;
        apply("wr_timeout", 24'h000800, 2'b11, 16'hDEAD, 1, 0, 1'b0, 16'h0, 1, TMO + 1, 1);
        model_commit(24'h000800, 2'b11, 16'hDEAD, 1'b1);
        ack_en = 1'b1;
        apply("rd_after_wr_abort", 24'h000800, 2'b00, 16'h0, 1, 0, 1'b1, ref_mem[12'h400], 0, 0, 0);

        // Invalidate coinciding with the read ack.
        inval_on_ack = 1'b1;
        apply("rd_inval_ack", 24'h000402, 2'b00, 16'h0, 2, 0, 1'b1, ref_mem[12'h201], 1, 3, 0);
        inval_on_ack = 1'b0;
        model_commit(24'h000402, 2'b00, 16'h0, 1'b0);
        ref_valid = 1'b0;
        apply("rd_after_inval", 24'h000402, 2'b00, 16'h0, 1, 0, 1'b1, ref_mem[12'h201], 1, 2, 0);
        model_commit(24'h000402, 2'b00, 16'h0, 1'b0);

        // Reset while a request is outstanding.
        ack_en = 1'b0;
        cpu_addr = 24'h000600; cpu_we = 2'b00; cen_in = 1'b1;
        repeat (3) @(negedge clk);
        check("req_before_reset", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_cpu_cen", 32'(cpu_cen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; cen_in = 1'b0; cpu_addr = 24'h000402;
        ack_en = 1'b1; ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0; cen_in = 1'b1;
        #1;
        check("rst_clears_valid", 32'(cpu_cen), 32'd0);
        check("stray_ack_din", 32'(cpu_din), 32'd0);
        check("stray_ack_req", 32'(mem_req), 32'd0);
        cen_in = 1'b0;
        @(negedge clk);
        ref_valid = 1'b0;
        apply("rd_after_reset", 24'h000402, 2'b00, 16'h0, 1, 0, 1'b1, ref_mem[12'h201], 1, 2, 0);
        model_commit(24'h000402, 2'b00, 16'h0, 1'b0);

        // Random traffic over a few words so hits, merges and misses all occur.
        for (int k = 0; k < 80; k++) begin
            a    = {20'h0, 4'($urandom_range(0, 15))};
            w    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            d    = 16'($urandom);
            dly  = int'($urandom_range(1, 4));
            dead = int'($urandom_range(0, 1));
            h    = (w == 2'b00) && model_hit(a);
            apply($sformatf("rnd%0d", k), a, w, d, dly, dead, w == 2'b00, ref_mem[a[12:1]],
                  h ? 0 : 1, h ? 0 : dly + 1, 0);
            model_commit(a, w, d, 1'b0);
            if ($urandom_range(0, 5) == 0) begin
                cen_in = 1'b0; inval_drv = 1'b1;
                @(negedge clk);
                inval_drv = 1'b0;
                ref_valid = 1'b0;
            end
        end

        check("mem_fields_stable", 32'(stab_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
